qspi_xip_sequencer: RTL and testbench
=====================================

QSPI_XIP_SEQUENCER -- requirements
Module: qspi_xip_sequencer

Interface
REQ-001 SHALL provide parameter ADDR_W, default 24, meaning flash address width in bits; legal values are multiples of 4.
REQ-002 SHALL provide parameter CS_HIGH_CYC, default 4, meaning the minimum number of clk cycles cs_n is held high between sequences.
REQ-003 SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-004 clk  in  1  system clock (AHB h_clk domain).
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a new XIP read sequence.
REQ-007 addr  in  ADDR_W  flash start address, sampled with start.
REQ-008 burst_len  in  4  number of 32-bit beats minus 1, sampled with start.
REQ-009 cmd  in  8  read opcode, sampled with start.
REQ-010 dummy_cyc  in  4  number of dummy SCK cycles (0-15), sampled with start.
REQ-011 abort  in  1  terminates any active sequence.
REQ-012 rdata_ready  in  1  consumer accepts rdata.
REQ-013 io_in  in  4  QSPI IO[3:0] input.
REQ-014 busy  out  1  high from the cycle after accepted start until return to IDLE.
REQ-015 rdata  out  32  assembled read word.
REQ-016 rdata_valid  out  1  rdata holds a complete word.
REQ-017 sck  out  1  QSPI serial clock, SPI mode 0.
REQ-018 cs_n  out  1  QSPI chip select, active low.
REQ-019 io_out  out  4  QSPI IO[3:0] output.
REQ-020 io_oe  out  4  per-line output enable.

Function
REQ-021 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, WAIT_ACK, CS_HOLD; all outputs registered.
REQ-022 SHALL generate sck at clk/2: each SCK period is one clk with sck=0, then one clk with sck=1; io_out changes only while sck=0; io_in is sampled at the clk edge where sck rises.
REQ-023 IDLE: start accepted only in IDLE; sample addr/burst_len/cmd/dummy_cyc; next state CMD; cs_n low and busy high in the next cycle; start outside IDLE is ignored.
REQ-024 CMD: 8 SCK cycles, cmd MSB first on io_out[0]; io_oe=4'b0001.
REQ-025 ADDR: ADDR_W/4 SCK cycles, quad, most significant nibble first; io_oe=4'b1111.
REQ-026 DUMMY: dummy_cyc SCK cycles, io_oe=4'b0000; dummy_cyc=0 means ADDR goes directly to DATA.
REQ-027 DATA: 8 SCK cycles per beat, io_oe=4'b0000; bytes assembled little-endian (first byte to rdata[7:0]), high nibble of each byte first.
REQ-028 SHALL assert rdata_valid in the clk after the 8th sampling edge of a beat and enter WAIT_ACK.
REQ-029 WAIT_ACK: sck held 0, cs_n held low, rdata stable; on rdata_valid&&rdata_ready, rdata_valid drops next cycle; go to DATA if beats remain, else CS_HOLD.
REQ-030 Beat counter SHALL count burst_len+1 beats (1-16); burst_len=4'hF means 16 beats with no overflow.
REQ-031 CS_HOLD: cs_n=1, sck=0, io_oe=0 for CS_HIGH_CYC cycles, then IDLE with busy=0.
REQ-032 Abort in any state other than IDLE/CS_HOLD SHALL move to CS_HOLD next cycle and clear rdata_valid; a partially assembled word is discarded; abort in IDLE or CS_HOLD has no effect.
REQ-033 If abort and rdata_ready coincide in WAIT_ACK, the handshake completes and abort wins (CS_HOLD).
REQ-034 Sequence latency for 1 beat SHALL be 2*(8+ADDR_W/4+dummy_cyc+8) clk from the first cs_n-low cycle to rdata_valid, ±1.

Reset
REQ-035 On rst_n low, at any time including mid-sequence, SHALL immediately force IDLE, cs_n=1, sck=0, io_out=0, io_oe=0, busy=0, rdata_valid=0, rdata=0, and clear all counters.
REQ-036 The first start after reset release SHALL be accepted normally with no CS_HOLD preamble.

Verification
REQ-037 start, cmd=8'hEB, addr=24'h123456, dummy_cyc=4, burst_len=0, rdata_ready=1, flash model returns bytes 11 22 33 44 -> rdata=32'h44332211, exactly 26 SCK rising edges, cs_n high for 4 clk, then busy=0.
REQ-038 burst_len=3, rdata_ready low for 10 clk on beat 2 -> sck frozen low, cs_n low, rdata stable throughout; 4 words delivered in order; 8+6+4+32 SCK total.
REQ-039 dummy_cyc=0 -> no gap between last address SCK and first data SCK; io_oe goes 4'b1111 to 4'b0000 at the ADDR/DATA boundary.
REQ-040 abort during DATA beat 1 of a 4-beat burst -> cs_n high the next cycle, rdata_valid never asserted, busy low after 4+1 clk; a subsequent start runs cleanly.
REQ-041 rst_n asserted during ADDR -> all outputs at reset values asynchronously; start in the first cycle after release is accepted.
REQ-042 start pulsed during DUMMY -> ignored; the transaction completes unchanged with its original addr.

Source files
------------

// File: rtl/qspi_xip_sequencer.sv
// Quad-SPI execute-in-place read sequencer: opcode on IO0, quad address, dummy
// cycles, then quad data assembled into 32-bit little-endian words.
module qspi_xip_sequencer #(
    parameter int ADDR_W      = 24,
    parameter int CS_HIGH_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        burst_len,
    input  logic [7:0]        cmd,
    input  logic [3:0]        dummy_cyc,
    input  logic              abort,
    input  logic              rdata_ready,
    input  logic [3:0]        io_in,
    output logic              busy,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              sck,
    output logic              cs_n,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W / 4 - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CS_HIGH_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, DATA, WAIT_ACK, CS_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        beat_q, beat_d;
    logic [3:0]        burst_q, burst_d;
    logic [3:0]        dummy_q, dummy_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       sh_q, sh_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              sck_q, sck_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic [3:0]        io_out_q, io_out_d;
    logic [3:0]        io_oe_q, io_oe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            beat_q        <= '0;
            burst_q       <= '0;
            dummy_q       <= '0;
            cmd_q         <= '0;
            addr_q        <= '0;
            sh_q          <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            sck_q         <= 1'b0;
            cs_n_q        <= 1'b1;
            busy_q        <= 1'b0;
            io_out_q      <= '0;
            io_oe_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            beat_q        <= beat_d;
            burst_q       <= burst_d;
            dummy_q       <= dummy_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            sh_q          <= sh_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            sck_q         <= sck_d;
            cs_n_q        <= cs_n_d;
            busy_q        <= busy_d;
            io_out_q      <= io_out_d;
            io_oe_q       <= io_oe_d;
        end
    end

    // Each SCK period: a cycle with sck_q=0 (drive/hold io_out), then sck_q=1.
    // Sampling happens on the edge that raises sck; phase advance on the edge that lowers it.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        beat_d        = beat_q;
        burst_d       = burst_q;
        dummy_d       = dummy_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        sh_d          = sh_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        sck_d         = 1'b0;
        io_out_d      = io_out_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CMD;
                    cmd_d    = cmd;
                    addr_d   = addr;
                    burst_d  = burst_len;
                    dummy_d  = dummy_cyc;
                    cnt_d    = '0;
                    beat_d   = '0;
                    io_out_d = {3'b000, cmd[7]};
                end
            end
            CMD: begin
                if (!sck_q) begin
                    sck_d = 1'b1;
                end else if (cnt_q == CNT_W'(7)) begin
                    state_d  = ADDR;
                    cnt_d    = '0;
                    io_out_d = addr_q[ADDR_W-1 -: 4];
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    cmd_d    = {cmd_q[6:0], cmd_q[7]};
                    io_out_d = {3'b000, cmd_d[7]};
                end
            end
            ADDR: begin
                if (!sck_q) begin
                    sck_d = 1'b1;
                end else if (cnt_q == ADDR_LAST) begin
                    state_d = (dummy_q == 4'd0) ? DATA : DUMMY;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    addr_d   = {addr_q[ADDR_W-5:0], addr_q[ADDR_W-1 -: 4]};
                    io_out_d = addr_d[ADDR_W-1 -: 4];
                end
            end
            DUMMY: begin
                if (!sck_q) begin
                    sck_d = 1'b1;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(dummy_q)) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (!sck_q) begin
                    sck_d = 1'b1;
                    // nibble n lands in byte n/2, high half first
                    sh_d[{cnt_q[2:1], ~cnt_q[0], 2'b00} +: 4] = io_in;
                end else if (cnt_q == CNT_W'(7)) begin
                    state_d       = WAIT_ACK;
                    cnt_d         = '0;
                    rdata_d       = sh_q;
                    rdata_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_ACK: begin
                // rdata/rdata_valid transfer on any cycle where both rdata_valid and rdata_ready are high
                if (rdata_ready) begin
                    rdata_valid_d = 1'b0;
                    cnt_d         = '0;
                    if (beat_q == burst_q) begin
                        state_d = CS_HOLD;
                    end else begin
                        state_d = DATA;
                        beat_d  = beat_q + 4'd1;
                    end
                end
            end
            CS_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE && state_q != CS_HOLD) begin
            state_d       = CS_HOLD;
            cnt_d         = '0;
            rdata_valid_d = 1'b0;
            sck_d         = 1'b0;
        end

        cs_n_d = (state_d == IDLE) || (state_d == CS_HOLD);
        busy_d = (state_d != IDLE);
        unique case (state_d)
            CMD:     io_oe_d = 4'b0001;
            ADDR:    io_oe_d = 4'b1111;
            default: io_oe_d = 4'b0000;
        endcase
        if (state_d != CMD && state_d != ADDR) begin
            io_out_d = '0;
        end
    end

    assign busy        = busy_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign sck         = sck_q;
    assign cs_n        = cs_n_q;
    assign io_out      = io_out_q;
    assign io_oe       = io_oe_q;

endmodule

// File: tb/tb_qspi_xip_sequencer.sv
// Bench for qspi_xip_sequencer: a behavioural quad flash decodes the command and
// address from the bus and serves bytes from a memory image; words are scored in order.
module tb_qspi_xip_sequencer;

    localparam int ADDR_W  = 24;
    localparam int AN      = ADDR_W / 4;
    localparam int CS_HIGH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        burst_len;
    logic [7:0]        cmd;
    logic [3:0]        dummy_cyc;
    logic              abort;
    logic              rdata_ready;
    logic [3:0]        io_in = 4'h0;
    logic              busy;
    logic [31:0]       rdata;
    logic              rdata_valid;
    logic              sck;
    logic              cs_n;
    logic [3:0]        io_out;
    logic [3:0]        io_oe;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_word;

    always #5 clk = ~clk;

    qspi_xip_sequencer #(.ADDR_W(ADDR_W), .CS_HIGH_CYC(CS_HIGH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .burst_len(burst_len),
        .cmd(cmd), .dummy_cyc(dummy_cyc), .abort(abort), .rdata_ready(rdata_ready),
        .io_in(io_in), .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid),
        .sck(sck), .cs_n(cs_n), .io_out(io_out), .io_oe(io_oe)
    );

    // ---------------- flash model ----------------
    logic [7:0]        mem [256];
    int                rises = 0;
    int                hdr = 18;
    logic [7:0]        cmd_cap = '0;
    logic [ADDR_W-1:0] addr_cap = '0;
    bit                oe_bad = 1'b0;
    longint            t_last_addr = 0;
    longint            t_first_data = 0;

    always @(negedge cs_n) begin
        rises  = 0;
        oe_bad = 1'b0;
    end

    always @(posedge sck) begin
        #2;
        rises = rises + 1;
        if (rises <= 8) begin
            cmd_cap = {cmd_cap[6:0], io_out[0]};
            if (io_oe !== 4'b0001) oe_bad = 1'b1;
        end else if (rises <= 8 + AN) begin
            addr_cap = {addr_cap[ADDR_W-5:0], io_out};
            if (io_oe !== 4'b1111) oe_bad = 1'b1;
            if (rises == 8 + AN) t_last_addr = $time;
        end else begin
            if (io_oe !== 4'b0000) oe_bad = 1'b1;
            if (rises == hdr + 1) t_first_data = $time;
        end
    end

    always @(negedge sck) begin
        int k;
        logic [7:0] idx;
        logic [7:0] b;
        #2;
        k = rises - hdr;
        if (k >= 0) begin
            idx   = 8'(int'(addr_cap[7:0]) + k / 2);
            b     = mem[idx];
            io_in = (k % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_word(input logic [ADDR_W-1:0] a, input int w);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = mem[8'(int'(a[7:0]) + 4 * w + j)];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"}, cs_n, 1);
        chk({tag, "_sck"}, sck, 0);
        chk({tag, "_io_out"}, io_out, 0);
        chk({tag, "_io_oe"}, io_oe, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdata_valid"}, rdata_valid, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    // Caller positions time just after a rising clk edge; start is driven in this cycle.
    task automatic do_txn(input logic [7:0] c, input logic [ADDR_W-1:0] a, input logic [3:0] bl,
                          input logic [3:0] dc, input int stall_beat, input int stall_len,
                          input int abort_rise, input int glitch_rise);
        int nbeats, cyc, lat, nb, stall_cnt, valid_seen, hold_cyc, abort_cyc, end_cyc, e_lat;
        bit done, glitched;
        logic [31:0] held, got;
        nbeats = int'(bl) + 1;
        hdr = 8 + AN + int'(dc);
        lat = -1; nb = 0; stall_cnt = 0; valid_seen = 0; hold_cyc = 0;
        abort_cyc = -10; end_cyc = 0; done = 1'b0; glitched = 1'b0; held = '0;
        if (abort_rise < 0)
            for (int w = 0; w < nbeats; w++) exp_q.push_back(exp_word(a, w));
        start = 1'b1; cmd = c; addr = a; burst_len = bl; dummy_cyc = dc; abort = 1'b0;
        rdata_ready = !(stall_beat == 0 && stall_len > 0);
        @(posedge clk); #1;
        start = 1'b0;
        cmd = 8'($urandom); addr = ADDR_W'($urandom); burst_len = 4'($urandom); dummy_cyc = 4'($urandom);
        @(negedge clk);
        chk("first_busy", busy, 1);
        chk("first_cs_n", cs_n, 0);
        cyc = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            if (rdata_valid) begin
                if (valid_seen == 0) lat = cyc;
                valid_seen++;
                if (rdata_ready) begin
                    chk("word_avail", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        got = exp_q.pop_front();
                        chk("rdata", rdata, got);
                        last_word = rdata;
                    end
                    nb++;
                end else begin
                    if (stall_cnt == 0) held = rdata;
                    else chk("stall_rdata", rdata, held);
                    chk("stall_sck", sck, 0);
                    chk("stall_cs_n", cs_n, 0);
                    stall_cnt++;
                end
            end
            if (cyc == abort_cyc + 1) begin
                chk("abort_cs_n", cs_n, 1);
                chk("abort_valid", rdata_valid, 0);
            end
            if (cs_n && busy) hold_cyc++;
            if (!busy) begin
                done = 1'b1;
                end_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                start = 1'b0;
                abort = 1'b0;
                if (glitch_rise >= 0 && !glitched && rises == glitch_rise) begin
                    start = 1'b1;
                    glitched = 1'b1;
                end
                if (abort_rise >= 0 && abort_cyc < 0 && rises == abort_rise) begin
                    abort = 1'b1;
                    abort_cyc = cyc + 1;
                end
                rdata_ready = !(nb == stall_beat && stall_cnt < stall_len);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; abort = 1'b0; rdata_ready = 1'b1;
        chk("txn_done", done, 1);
        chk("cmd_seen", cmd_cap, c);
        chk("addr_seen", addr_cap, a);
        chk("io_oe_phases", oe_bad, 0);
        chk("cs_hold_cycles", hold_cyc, CS_HIGH);
        if (abort_rise < 0) begin
            e_lat = 2 * (hdr + 8);
            checks++;
            assert (lat >= e_lat - 1 && lat <= e_lat + 1) else begin
                errors++;
                $error("FAIL latency observed=%0d expected=%0d+-1", lat, e_lat);
            end
            chk("beats", nb, nbeats);
            chk("sck_rises", rises, hdr + 8 * nbeats);
            chk("data_gap", 32'(t_first_data - t_last_addr), 20 * (int'(dc) + 1));
            chk("exp_left", exp_q.size(), 0);
        end else begin
            chk("abort_no_valid", valid_seen, 0);
            chk("abort_busy_drop", end_cyc - abort_cyc, 5);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        logic [7:0]        rc;
        logic [ADDR_W-1:0] ra;
        logic [3:0]        rb, rd;
        int                sb;
        rst_n = 1'b1; start = 1'b0; addr = '0; burst_len = '0; cmd = '0; dummy_cyc = '0;
        abort = 1'b0; rdata_ready = 1'b1; last_word = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h56] = 8'h11; mem[8'h57] = 8'h22; mem[8'h58] = 8'h33; mem[8'h59] = 8'h44;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");

        // first start right after release, reference read
        @(posedge clk); #1; rst_n = 1'b1;
        do_txn(8'hEB, 24'h123456, 4'd0, 4'd4, -1, 0, -1, -1);
        chk("ref_word", last_word, 32'h44332211);

        // 4-beat burst with consumer stalling on the second beat
        @(posedge clk); #1;
        do_txn(8'hEB, 24'h200040, 4'd3, 4'd4, 1, 10, -1, -1);

        // no dummy cycles: address runs straight into data
        @(posedge clk); #1;
        do_txn(8'h6B, 24'h3000F0, 4'd1, 4'd0, -1, 0, -1, -1);

        // abort inside the first data beat, then a clean sequence
        @(posedge clk); #1;
        do_txn(8'hEB, 24'h000100, 4'd3, 4'd4, -1, 0, 8 + AN + 4 + 3, -1);
        @(posedge clk); #1;
        do_txn(8'h0B, 24'h0A0B20, 4'd0, 4'd8, -1, 0, -1, -1);

        // maximum burst length
        @(posedge clk); #1;
        do_txn(8'hEB, 24'h400010, 4'hF, 4'd2, 5, 3, -1, -1);

        // reset while the address is being shifted
        @(posedge clk); #1;
        start = 1'b1; cmd = 8'hEB; addr = 24'h555555; burst_len = 4'd0; dummy_cyc = 4'd2;
        hdr = 8 + AN + 2;
        @(posedge clk); #1;
        start = 1'b0;
        reached = 1'b0;
        for (int t = 0; t < 200 && !reached; t++) begin
            @(posedge clk); #3;
            if (rises >= 10) reached = 1'b1;
        end
        chk("reached_addr", reached, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(posedge clk); #1; rst_n = 1'b1;
        do_txn(8'hEB, 24'h654321, 4'd1, 4'd2, -1, 0, -1, -1);

        // start pulsed during dummy cycles is ignored
        @(posedge clk); #1;
        do_txn(8'h6B, 24'hABCDEF, 4'd1, 4'd4, -1, 0, -1, 8 + AN + 4 - 2);

        for (int i = 0; i < 6; i++) begin
            rc = 8'($urandom);
            ra = ADDR_W'($urandom);
            rb = 4'($urandom_range(0, 3));
            rd = 4'($urandom_range(0, 15));
            sb = $urandom_range(0, int'(rb));
            @(posedge clk); #1;
            do_txn(rc, ra, rb, rd, sb, $urandom_range(0, 6), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
